// File: rtl/mux_arb_2ch.sv
// Two-channel round-robin burst arbiter driving a shared 2:1 datapath mux,
// with a registered valid/ready output stage. Optional beat limit: ARB_BURST_LIMIT_EN.
module mux_arb_2ch #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic             valid0,
    input  logic             valid1,
    input  logic [WIDTH-1:0] data0,
    input  logic [WIDTH-1:0] data1,
    input  logic             last0,
    input  logic             last1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             ready0,
    output logic             ready1,
    output logic             sel,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    input  logic             out_ready
);

    localparam int unsigned CNT_W = 8;

    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
        $error("MAX_BURST must be in 1..255");
    end

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state_q, state_d;
    logic   ptr_q, ptr_d;
    logic   sel_q, sel_d;
    logic   out_free;
    logic   acc0, acc1, acc;
    logic   beat_last;
    logic   limit_hit;
    logic   burst_end;

    // Grants decode straight from the state register; ready opens only when the output slot frees
    assign gnt0     = (state_q == GNT0);
    assign gnt1     = (state_q == GNT1);
    assign sel      = sel_q;
    assign out_free = !out_valid || out_ready;
    assign ready0   = gnt0 && out_free;
    assign ready1   = gnt1 && out_free;
    assign acc0     = valid0 && ready0;
    assign acc1     = valid1 && ready1;
    assign acc      = acc0 || acc1;
    assign beat_last = sel_q ? last1 : last0;

`ifdef ARB_BURST_LIMIT_EN
    logic [CNT_W-1:0] cnt_q;

    assign limit_hit = (cnt_q == CNT_W'(MAX_BURST - 1));

    // Beats accepted in the current grant; cleared whenever the grant ends
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (burst_end) begin
            cnt_q <= '0;
        end else if (acc) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end
`else
    assign limit_hit = 1'b0;
`endif

    assign burst_end = acc && (beat_last || limit_hit);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
        end
    end

    // Next-state: hand over to the other requester first, else re-grant, else idle
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        case (state_q)
            IDLE: begin
                if (req0 && (!req1 || !ptr_q)) begin
                    state_d = GNT0;
                end else if (req1) begin
                    state_d = GNT1;
                end
            end
            GNT0: begin
                if (burst_end) begin
                    ptr_d = 1'b1;
                    if (req1) begin
                        state_d = GNT1;
                    end else if (req0) begin
                        state_d = GNT0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GNT1: begin
                if (burst_end) begin
                    ptr_d = 1'b0;
                    if (req0) begin
                        state_d = GNT0;
                    end else if (req1) begin
                        state_d = GNT1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d == GNT0) begin
            sel_d = 1'b0;
        end else if (state_d == GNT1) begin
            sel_d = 1'b1;
        end
    end

    // Output stage: load on accept (even while draining), otherwise drain
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else if (acc) begin
            out_valid <= 1'b1;
            out_data  <= sel_q ? data1 : data0;
            out_last  <= beat_last;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/mux_arb_2ch.md
# mux_arb_2ch

Round-robin arbiter and sequencer that shares one 32-bit 2:1 datapath mux between two requesters, such as the instruction-fetch and data-memory ports of the multicycle core. It grants one channel at a time for a burst and drives the mux select. Accepted beats are passed through a registered output stage with a valid/ready handshake. Bursts end on `last`, or optionally on a beat limit, and fairness is guaranteed by a rotating priority pointer.

## Interface
- `WIDTH`, 32, data path width of both channels and the output.
- `MAX_BURST`, 8, maximum beats per grant when the burst limit is compiled in (legal range 1..255).
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0`, `req1`  in  1  channel requests a grant; must stay high until the channel's final beat is accepted.
- `valid0`, `valid1`  in  1  channel beat present on `data0` / `data1`.
- `data0`, `data1`  in  WIDTH  channel beat data.
- `last0`, `last1`  in  1  marks the final beat of the burst.
- `gnt0`, `gnt1`  out  1  registered grant; one-hot or both zero.
- `ready0`, `ready1`  out  1  beat accepted this cycle when `valid` and `ready` are both high.
- `sel`  out  1  mux select (the mux's `select_b`); 0 selects channel 0, 1 selects channel 1.
- `out_valid`  out  1  output register holds a beat.
- `out_data`  out  WIDTH  output beat.
- `out_last`  out  1  output beat is the last of its burst.
- `out_ready`  in  1  downstream accepts the output beat.

## Operation
- States: IDLE, GNT0, GNT1. Priority pointer `ptr`: 0 favours channel 0, 1 favours channel 1.
- IDLE:
  - `req0` only → GNT0.
  - `req1` only → GNT1.
  - Both → the channel given by `ptr`.
  - Neither → stay in IDLE.
- In GNTi: `gnt_i`=1, `sel`=i, `ready_i = gnt_i & (!out_valid | out_ready)`. The other channel's ready is 0.
- Accept: on `valid_i & ready_i`, `out_data`←`data_i`, `out_last`←`last_i`, `out_valid`←1, and the beat counter increments.
- Output drain: if `out_valid & out_ready` and no new accept that cycle, `out_valid`←0.
- Burst end:
  - Triggers: an accepted beat with `last_i`=1, or the burst limit (see Configuration).
  - On burst end, `ptr`←!i and the beat counter clears.
  - Next state: if the other channel is requesting, go directly to GNT(!i) with no idle bubble. Else if `req_i` is still high, re-grant GNTi. Else go to IDLE.
- In IDLE, `sel` holds its last value and `gnt0`=`gnt1`=0.
- `req` is ignored while its channel is granted. Dropping `req` mid-burst has no effect; only `last` or the limit ends the grant.
- Beat counter is 8 bits and never wraps, because the limit is at most 255.

## Timing
- Reset values: state IDLE, `ptr`=0, `sel`=0, `gnt0`=`gnt1`=0, `ready0`=`ready1`=0, `out_valid`=0, `out_data`=0, `out_last`=0, counter 0.
- Grant latency: `req` high in cycle N → `gnt` high in cycle N+1. The first beat can be accepted in N+1.
- Data latency: a beat accepted at edge E appears on `out_data` / `out_valid` after E. Throughput is 1 beat/cycle while `out_ready`=1.
- Back-pressure: `out_valid`=1 and `out_ready`=0 forces `ready`=0 and holds `out_data` stable.
- Burst switch: last beat of channel 0 accepted at edge E with `req1` high → `gnt1`=1 and `sel`=1 after E. Channel 1's first beat can be accepted in the next cycle.
- Simultaneous accept and drain in the same cycle: the output register loads the new beat and `out_valid` stays 1.
- Reset mid-burst: all state clears immediately and asynchronously. An in-flight output beat is dropped.

## Configuration
- `ARB_BURST_LIMIT_EN` defined:
  - The grant also ends after `MAX_BURST` accepted beats even without `last`.
  - The pointer rotates as for a normal burst end.
  - The preempted channel keeps `req` high and is re-granted later; its continuation beats follow without a repeated header.
- Not defined: the grant ends only on `last`, the counter is absent, and `MAX_BURST` is unused.

## Test plan
- **Reset:** assert `reset` mid-burst with `out_valid`=1 → all outputs reach their reset values asynchronously, and state is IDLE after release.
- **Single channel:** `req0`=1, 3 beats 0xA0..0xA2 with `last` on the third, `out_ready`=1 → `gnt0` in cycle 1, outputs 0xA0, 0xA1, 0xA2 on consecutive cycles with `out_last` on 0xA2, then IDLE.
- **Contention:** `req0`=`req1`=1 from reset, 2-beat bursts each → order ch0, ch1, ch0, ch1. `sel` toggles with no bubble cycle between bursts.
- **Back-pressure:** hold `out_ready`=0 for 4 cycles with `out_data`=0x12345678 → `ready0`=0 and `out_data` stays stable; release → the next beat follows in the following cycle.
- **Burst limit** (`ARB_BURST_LIMIT_EN`, `MAX_BURST`=4): ch0 10-beat burst with `req1`=1 → ch0 beats 1-4, ch1 burst, ch0 beats 5-8, and so on.
- **Burst limit disabled** (macro undefined), same stimulus → all 10 ch0 beats first, then ch1.
